// File: rtl/rr_requester_bank.sv
// rr_requester_bank: four per-port FIFOs feeding a round-robin arbiter.
// Raises REQ toward the arbiter, pops one word per valid grant onto a shared
// output bus tagged with the source port, and flags grant protocol errors.

// Single-port circular FIFO; head word is always visible combinationally.
module rr_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           head,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rptr];
endmodule

module rr_requester_bank #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      REQ,
  input  logic [3:0]      GNT,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_port,
  output logic            err_grant,
  output logic            err_onehot
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [3:0][CW-1:0] count;
  logic [3:0][DW-1:0] head;
  logic [3:0]         push, pop;
  logic               onehot;
  logic [1:0]         g;
  logic               g_nonempty;

  assign onehot = (GNT != 4'b0) && ((GNT & (GNT - 4'b1)) == 4'b0);

  for (genvar i = 0; i < 4; i++) begin : g_port
    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even in a cycle where it is also being popped.
    assign in_ready[i] = (count[i] < FULL);
    assign push[i]     = in_valid[i] && in_ready[i];
    assign pop[i]      = GNT[i] && (count[i] != '0) && onehot;
    // Drop REQ during the grant that drains the last word so the arbiter
    // never re-grants an empty port.
    assign REQ[i]      = rst_n && (count[i] > {{(CW-1){1'b0}}, GNT[i]});

    rr_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_data[i*DW +: DW]),
      .head  (head[i]),
      .count (count[i])
    );
  end

  // Encode the granted index; only meaningful when GNT is one-hot.
  always_comb begin
    g = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (GNT[i]) g = 2'(i);
    end
  end

  assign g_nonempty = (count[g] != '0);
  assign out_valid  = rst_n && onehot && g_nonempty;
  assign out_data   = out_valid ? head[g] : '0;
  assign out_port   = out_valid ? g : 2'd0;

  // Sticky protocol error flags; a multi-hot grant is reported only as
  // err_onehot, never as a per-port empty grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_grant  <= 1'b0;
      err_onehot <= 1'b0;
    end else begin
      if (onehot && !g_nonempty)         err_grant  <= 1'b1;
      if ((GNT & (GNT - 4'b1)) != 4'b0)  err_onehot <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_requester_bank.sv
// Directed bench for rr_requester_bank: stimulus pushes hand-computed
// expected (port,data) pairs into a queue, a negedge monitor pops and compares.
module tb_rr_requester_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  REQ;
  logic [3:0]  GNT;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        err_grant, err_onehot;

  logic        arb_en;
  logic [3:0]  gnt_man, gnt_arb, arb_next;
  logic [1:0]  last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_exp;

  always #5 clk = ~clk;

  assign GNT = arb_en ? gnt_arb : gnt_man;

  rr_requester_bank #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .REQ(REQ), .GNT(GNT), .out_valid(out_valid),
    .out_data(out_data), .out_port(out_port), .err_grant(err_grant),
    .err_onehot(err_onehot)
  );

  // Round-robin arbiter model: next requester after the last granted one.
  always_comb begin
    arb_next = 4'b0;
    for (int k = 1; k <= 4; k++) begin
      if (arb_next == 4'b0 && REQ[(int'(last) + k) % 4])
        arb_next[(int'(last) + k) % 4] = 1'b1;
    end
  end

  // Grant is registered from REQ, as in the real arbiter.
  always @(posedge clk) begin
    if (!rst_n || !arb_en) begin
      gnt_arb <= 4'b0;
      if (!rst_n) last <= 2'd3;
    end else begin
      gnt_arb <= arb_next;
      for (int k = 0; k < 4; k++) if (arb_next[k]) last <= 2'(k);
    end
  end

  // Output monitor: every presented word must match the queue head.
  always @(negedge clk) begin
    if (out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got port %0d data %h, queue empty", out_port, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_port, out_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL output_word: got port %0d data %h, want port %0d data %h",
                   out_port, out_data, mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_word(input logic [1:0] p, input logic [7:0] d);
    exp_q.push_back({p, d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; gnt_man = '0; arb_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_req", 32'(REQ), 32'h0);
    chk("rst_out", {21'b0, out_valid, out_port, out_data}, 32'h0);
    chk("rst_flags", {30'b0, err_grant, err_onehot}, 32'h0);

    // Single word latency through the arbiter model
    step();
    arb_en = 1'b1; in_valid = 4'b0001; in_data[7:0] = 8'hA5;
    expect_word(2'd0, 8'hA5);
    step(); in_valid = '0;
    @(negedge clk); chk("t1_req_n1", 32'(REQ), 32'h1);
    step();
    @(negedge clk); chk("t1_gnt_n2", 32'(GNT), 32'h1); chk("t1_req_n2", 32'(REQ), 32'h0);
    step(); step(); step();
    chk("t1_drained", exp_q.size(), 0);

    // Interleaving two ports via the arbiter model
    do_reset();
    in_valid = 4'b0101; in_data[7:0] = 8'h11; in_data[23:16] = 8'h31;
    step();
    in_valid = 4'b0001; in_data[7:0] = 8'h12;
    step();
    in_valid = '0;
    expect_word(2'd0, 8'h11); expect_word(2'd2, 8'h31); expect_word(2'd0, 8'h12);
    arb_en = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("t2_req_idle", 32'(REQ), 32'h0);
    chk("t2_flags", {30'b0, err_grant, err_onehot}, 32'h0);
    chk("t2_drained", exp_q.size(), 0);

    // Full FIFO on port 1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0010; in_data[15:8] = 8'h40 + 8'(k);
      step();
    end
    in_data[15:8] = 8'h44;
    @(negedge clk); chk("t3_full_ready", 32'(in_ready[1]), 32'h0);
    step();
    gnt_man = 4'b0010; in_data[15:8] = 8'h55;
    expect_word(2'd1, 8'h40);
    @(negedge clk); chk("t3_pop_ready", 32'(in_ready[1]), 32'h0);
    step();
    gnt_man = '0; in_valid = '0;
    @(negedge clk); chk("t3_ready_back", 32'(in_ready[1]), 32'h1);
    expect_word(2'd1, 8'h41); expect_word(2'd1, 8'h42); expect_word(2'd1, 8'h43);
    gnt_man = 4'b0010;
    step(); step(); step();
    gnt_man = '0;
    @(negedge clk);
    chk("t3_req_empty", 32'(REQ), 32'h0);
    chk("t3_ready_all", 32'(in_ready), 32'hF);
    chk("t3_drained", exp_q.size(), 0);

    // Wrap-around with simultaneous push and pop on port 3
    do_reset();
    in_valid = 4'b1000; in_data[31:24] = 8'h70;
    step();
    for (int k = 0; k < 10; k++) begin
      in_data[31:24] = 8'h71 + 8'(k); gnt_man = 4'b1000;
      expect_word(2'd3, 8'h70 + 8'(k));
      step();
    end
    in_valid = '0; gnt_man = '0;
    @(negedge clk);
    chk("t4_req_hold", 32'(REQ), 32'h8);
    chk("t4_ready", 32'(in_ready), 32'hF);
    gnt_man = 4'b1000; expect_word(2'd3, 8'h7A);
    step(); gnt_man = '0;
    @(negedge clk);
    chk("t4_req_empty", 32'(REQ), 32'h0);
    chk("t4_drained", exp_q.size(), 0);

    // Protocol violations
    do_reset();
    gnt_man = 4'b0100;
    @(negedge clk);
    chk("t5_empty_gnt_ov", 32'(out_valid), 32'h0);
    chk("t5_flag_not_yet", 32'(err_grant), 32'h0);
    step(); gnt_man = '0;
    @(negedge clk);
    chk("t5_err_grant", {30'b0, err_grant, err_onehot}, 32'h2);
    in_valid = 4'b0011; in_data[7:0] = 8'h0A; in_data[15:8] = 8'h1B;
    step(); in_valid = '0; gnt_man = 4'b0011;
    @(negedge clk); chk("t5_multi_ov", 32'(out_valid), 32'h0);
    step(); gnt_man = '0;
    @(negedge clk);
    chk("t5_err_onehot", {30'b0, err_grant, err_onehot}, 32'h3);
    chk("t5_req_kept", 32'(REQ), 32'h3);
    expect_word(2'd0, 8'h0A); gnt_man = 4'b0001; step();
    expect_word(2'd1, 8'h1B); gnt_man = 4'b0010; step();
    gnt_man = '0;
    @(negedge clk);
    chk("t5_flags_sticky", {30'b0, err_grant, err_onehot}, 32'h3);
    chk("t5_drained", exp_q.size(), 0);

    // Reset mid-operation discards buffered words
    do_reset();
    @(negedge clk); chk("t6_flags_clr", {30'b0, err_grant, err_onehot}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001; in_data[7:0] = 8'hC0 + 8'(k);
      step();
    end
    in_valid = '0;
    @(negedge clk); chk("t6_req_before", 32'(REQ), 32'h1);
    step();
    rst_n = 1'b0; gnt_man = 4'b0001;
    @(negedge clk);
    chk("t6_req_in_rst", 32'(REQ), 32'h0);
    chk("t6_ov_in_rst", 32'(out_valid), 32'h0);
    step();
    rst_n = 1'b1; gnt_man = '0;
    @(negedge clk);
    chk("t6_ready_after", 32'(in_ready), 32'hF);
    chk("t6_req_after", 32'(REQ), 32'h0);
    chk("t6_flags_after", {30'b0, err_grant, err_onehot}, 32'h0);
    arb_en = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("t6_req_idle", 32'(REQ), 32'h0);
    chk("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
